beep_event_seq: RTL
===================

Name: beep_event_seq

Overview:
- Upstream stage of the beeper chain: turns one-cycle game event pulses (hit, miss, game over) into a timed `bee` gate pattern.
- `bee` drives the beeper top's `bee` input, which gates the melody generator.
- Runs on the 50 MHz system clock, with a millisecond prescaler for pattern timing.
- Fixed priority between events; higher-priority events preempt.

Parameters:
- CLK_PER_MS, 50000, system clock cycles per millisecond tick (set small, e.g. 4, in simulation).
- HIT_ON_MS, 80, single beep length for a hit.
- MISS_ON_MS, 60, beep length for each of the 2 miss beeps.
- MISS_OFF_MS, 60, gap between miss beeps.
- OVER_ON_MS, 200, beep length for each of the 3 game-over beeps.
- OVER_OFF_MS, 100, gap between game-over beeps.
- All *_MS values are in the range 1..255.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- evt_hit  input  1  one-cycle pulse: mole hit.
- evt_miss  input  1  one-cycle pulse: miss or timeout.
- evt_over  input  1  one-cycle pulse: game over.
- mute  input  1  level; forces `bee` low without stopping sequencing.
- bee  output  1  beeper gate, registered.
- busy  output  1  high while a pattern is running.
- cur_evt  output  2  code of the running pattern: 0 none, 1 hit, 2 miss, 3 over.

Behaviour:
- Reset is synchronous on rst=1 at a rising edge:
  - bee=0, busy=0, cur_evt=0.
  - FSM goes to IDLE; all counters clear.
  - Reset mid-pattern aborts the pattern immediately; no residual beep after rst deasserts.
- Event resolution:
  - Priority is over > miss > hit.
  - Simultaneous pulses in one cycle: only the highest is taken; the others are dropped, not queued.
- FSM states are IDLE, ON, OFF.
- IDLE:
  - A resolved event sampled at edge N starts its pattern.
  - At N+1: state=ON, bee=!mute, busy=1, cur_evt=code.
  - Load beeps_left (2 bits) with the beep count: hit 1, miss 2, over 3.
  - Load on_ms and off_ms from the pattern table.
- ON:
  - Lasts exactly on_ms*CLK_PER_MS cycles.
  - At the end, decrement beeps_left.
  - If beeps_left is now 0: go to IDLE; bee=0, busy=0, cur_evt=0 on the same edge. There is no trailing gap.
  - Otherwise go to OFF.
- OFF:
  - bee=0 for exactly off_ms*CLK_PER_MS cycles, then back to ON.
- Timing counters:
  - The ms prescaler (width clog2(CLK_PER_MS)) and the ms counter (8 bits) both clear on every pattern start and on every ON/OFF transition.
  - This makes phase lengths exact to the cycle. There is no free-running tick phase error.
- Events arriving while busy:
  - Strictly higher priority than cur_evt: preempt. The new pattern restarts from its first ON at the next edge, counters cleared, bee=!mute.
  - Equal or lower priority: ignored.
  - An event on the same edge as the pattern's final ON ends is evaluated as if from IDLE, so it is not lost.
- mute:
  - bee = phase_on & !mute, registered. Change visible one cycle after mute changes.
  - busy and cur_evt are unaffected by mute.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package beep_pkg holds:
  - Event code constants EVT_NONE=0, EVT_HIT=1, EVT_MISS=2, EVT_OVER=3.
  - The FSM state encoding.
  - Beep-count constants: hit 1, miss 2, over 3.
- Sub-module beep_ms_tick:
  - Prescaler with synchronous clear input.
  - Emits a one-cycle tick every CLK_PER_MS cycles after clear.
  - Instantiated once inside beep_event_seq.

Test Plan (CLK_PER_MS=4, HIT_ON_MS=2, MISS_ON_MS=1, MISS_OFF_MS=1, OVER_ON_MS=3, OVER_OFF_MS=2):
- evt_hit pulse at cycle 10 -> bee=1 cycles 11..18 (8 cycles), busy=1 for the same span, cur_evt=1, then all 0 at cycle 19.
- evt_miss pulse at cycle 10 -> bee high 11..14, low 15..18, high 19..22; busy=1 for 11..22; cur_evt=2.
- evt_hit, evt_miss and evt_over in the same cycle -> over pattern only: 3 bursts of 12 high cycles separated by 8 low cycles; cur_evt=3; the other two events are never played.
- Preemption and ignore:
  - evt_hit at 10, evt_over at 14 -> over pattern's first ON starts at 15 with a full 12 cycles; cur_evt=3.
  - evt_hit during the over pattern -> ignored; pattern timing unchanged.
- mute=1 throughout an evt_miss -> bee stays 0; busy/cur_evt sequence identical to the unmuted case.
- rst=1 for 1 cycle in the middle of the over pattern's second ON -> bee=0, busy=0, cur_evt=0 on the next edge; no activity until the next event.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared definitions for the beeper event sequencer.
// Contents:
//   - Event codes. Their numeric order is also their priority order.
//   - FSM state encoding.
//   - Beep count for each pattern.
//   - Event resolver that picks the highest-priority pulse.
package beep_pkg;

  localparam logic [1:0] EVT_NONE = 2'd0;
  localparam logic [1:0] EVT_HIT  = 2'd1;
  localparam logic [1:0] EVT_MISS = 2'd2;
  localparam logic [1:0] EVT_OVER = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam logic [1:0] BEEPS_HIT  = 2'd1;
  localparam logic [1:0] BEEPS_MISS = 2'd2;
  localparam logic [1:0] BEEPS_OVER = 2'd3;

  // Priority is over > miss > hit. Pulses that lose the resolution are dropped.
  function automatic logic [1:0] resolve_evt(input logic hit, input logic miss,
                                             input logic over);
    if (over)      return EVT_OVER;
    else if (miss) return EVT_MISS;
    else if (hit)  return EVT_HIT;
    else           return EVT_NONE;
  endfunction

endpackage

// File: rtl/beep_ms_tick.sv
// Millisecond prescaler.
// Emits a one-cycle tick every CLK_PER_MS cycles, counted from the last clear.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - synchronous restart of the count
//   tick - high for one cycle at the end of each millisecond
module beep_ms_tick #(
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_MS - 1);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt_q <= '0;
    else if (tick)   cnt_q <= '0;
    else             cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/beep_event_seq.sv
// Game-event beep sequencer.
// Turns one-cycle hit/miss/over pulses into a timed, registered beeper gate.
//
// state | meaning
// IDLE  | no pattern running, outputs low
// ON    | beep phase; bee follows !mute
// OFF   | gap between beeps; bee low
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   evt_hit/miss/over - one-cycle event pulses
//   mute              - level input; silences bee, sequencing continues
//   bee               - beeper gate
//   busy              - a pattern is running
//   cur_evt           - code of the running pattern
module beep_event_seq
  import beep_pkg::*;
#(
  parameter int unsigned CLK_PER_MS  = 50000,
  parameter int unsigned HIT_ON_MS   = 80,
  parameter int unsigned MISS_ON_MS  = 60,
  parameter int unsigned MISS_OFF_MS = 60,
  parameter int unsigned OVER_ON_MS  = 200,
  parameter int unsigned OVER_OFF_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       evt_hit,
  input  logic       evt_miss,
  input  logic       evt_over,
  input  logic       mute,
  output logic       bee,
  output logic       busy,
  output logic [1:0] cur_evt
);

  state_e     state_q;
  logic       bee_q, busy_q;
  logic [1:0] cur_evt_q, beeps_left_q;
  logic [7:0] on_ms_q, off_ms_q, ms_cnt_q;

  logic [1:0] evt_code, cur_eff, load_beeps;
  logic [7:0] phase_len, load_on, load_off;
  logic       tick, phase_done, final_end, start, clr;

  always_comb begin
    evt_code   = resolve_evt(evt_hit, evt_miss, evt_over);
    phase_len  = (state_q == ST_ON) ? on_ms_q : off_ms_q;
    // The phase ends on the tick that completes its last millisecond.
    phase_done = (state_q != ST_IDLE) && tick && (ms_cnt_q == phase_len - 8'd1);
    final_end  = (state_q == ST_ON) && phase_done && (beeps_left_q == 2'd1);
    // On the edge the last beep ends the block is effectively idle, so any
    // event arriving then starts its own pattern.
    cur_eff    = final_end ? EVT_NONE : cur_evt_q;
    start      = (evt_code > cur_eff);
    // Restarting the prescaler on every phase boundary keeps phases cycle-exact.
    clr        = start || phase_done;

    load_beeps = BEEPS_HIT;
    load_on    = 8'(HIT_ON_MS);
    load_off   = 8'd1;
    case (evt_code)
      EVT_MISS: begin
        load_beeps = BEEPS_MISS;
        load_on    = 8'(MISS_ON_MS);
        load_off   = 8'(MISS_OFF_MS);
      end
      EVT_OVER: begin
        load_beeps = BEEPS_OVER;
        load_on    = 8'(OVER_ON_MS);
        load_off   = 8'(OVER_OFF_MS);
      end
      default: ;
    endcase
  end

  beep_ms_tick #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bee_q        <= 1'b0;
      busy_q       <= 1'b0;
      cur_evt_q    <= EVT_NONE;
      beeps_left_q <= 2'd0;
      on_ms_q      <= 8'd0;
      off_ms_q     <= 8'd0;
      ms_cnt_q     <= 8'd0;
    end else if (start) begin
      state_q      <= ST_ON;
      bee_q        <= !mute;
      busy_q       <= 1'b1;
      cur_evt_q    <= evt_code;
      beeps_left_q <= load_beeps;
      on_ms_q      <= load_on;
      off_ms_q     <= load_off;
      ms_cnt_q     <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bee_q <= 1'b0;
        end
        ST_ON: begin
          if (phase_done) begin
            beeps_left_q <= beeps_left_q - 2'd1;
            ms_cnt_q     <= 8'd0;
            bee_q        <= 1'b0;
            if (beeps_left_q == 2'd1) begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              cur_evt_q <= EVT_NONE;
            end else begin
              state_q <= ST_OFF;
            end
          end else begin
            bee_q <= !mute;
            if (tick) ms_cnt_q <= ms_cnt_q + 8'd1;
          end
        end
        ST_OFF: begin
          if (phase_done) begin
            state_q  <= ST_ON;
            bee_q    <= !mute;
            ms_cnt_q <= 8'd0;
          end else begin
            bee_q <= 1'b0;
            if (tick) ms_cnt_q <= ms_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          bee_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bee     = bee_q;
  assign busy    = busy_q;
  assign cur_evt = cur_evt_q;

endmodule
